// File: rtl/program_loader_pkg.sv
// Shared definitions for the program store path: load FSM encoding and
// default widths used by the loader, controller and instruction memory.
package program_loader_pkg;

    localparam int LD_DATA_W = 5;
    localparam int LD_OP_W   = 5;
    localparam int LD_ADDR_W = 4;
    localparam int LD_DEPTH  = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_OP  = 3'd1,
        GET_VAL = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4,
        ERR     = 3'd5
    } load_state_t;

endpackage

// File: rtl/program_loader.sv
// Program loader: packs a 5-bit word stream into (opcode, operand) pairs and
// writes each pair into the program store through a single write port.
//
// Handshake: a stream word transfers on a rising edge where in_valid and
// in_ready are both high; in_ready depends only on the FSM state (high in
// GET_OP and GET_VAL) and in_data/in_last are ignored when nothing transfers.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DATA_W = LD_DATA_W,
    parameter int OP_W   = LD_OP_W,
    parameter int ADDR_W = LD_ADDR_W,
    parameter int DEPTH  = LD_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [OP_W-1:0]   wr_op,
    output logic [DATA_W-1:0] wr_val,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   prog_len,
    output logic [2:0]        dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    load_state_t       state;
    load_state_t       state_n;
    logic              load_start;
    logic [ADDR_W-1:0] addr_cnt;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] val_q;
    logic              last_q;

    // State register; reset drops straight to IDLE so wr_en falls at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_n    = state;
        in_ready   = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b0;
        load_done  = 1'b0;
        load_err   = 1'b0;
        load_start = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_start = 1'b1;
                    state_n    = GET_OP;
                end
            end
            GET_OP: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    // A program may only end on an operand word.
                    state_n = in_last ? ERR : GET_VAL;
                end
            end
            GET_VAL: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    state_n = WRITE;
                end
            end
            WRITE: begin
                wr_en = 1'b1;
                busy  = 1'b1;
                if (last_q) begin
                    state_n = DONE;
                end else if (addr_cnt == LAST_ADDR) begin
                    state_n = ERR;
                end else begin
                    state_n = GET_OP;
                end
            end
            DONE: begin
                load_done = 1'b1;
                if (start) begin
                    load_start = 1'b1;
                    state_n    = GET_OP;
                end
            end
            ERR: begin
                load_err = 1'b1;
                if (start) begin
                    load_start = 1'b1;
                    state_n    = GET_OP;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Word capture, address counter and program length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt <= '0;
            prog_len <= '0;
            op_q     <= '0;
            val_q    <= '0;
            last_q   <= 1'b0;
        end else begin
            if (load_start) begin
                addr_cnt <= '0;
                prog_len <= '0;
                last_q   <= 1'b0;
            end
            if (state == GET_OP && in_valid) begin
                // Opcode words keep only their low OP_W bits.
                op_q <= in_data[OP_W-1:0];
            end
            if (state == GET_VAL && in_valid) begin
                val_q  <= in_data;
                last_q <= in_last;
            end
            if (state == WRITE) begin
                addr_cnt <= addr_cnt + 1'b1;
                prog_len <= prog_len + 1'b1;
            end
        end
    end

    assign wr_addr   = addr_cnt;
    assign wr_op     = op_q;
    assign wr_val    = val_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected store writes go into a queue
// as pairs are driven and are popped by a write monitor on each wr_en.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int DATA_W = 5;
    localparam int OP_W   = 5;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int WR_W   = ADDR_W + OP_W + DATA_W;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [OP_W-1:0]   wr_op;
    logic [DATA_W-1:0] wr_val;
    logic              busy;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   prog_len;
    logic [2:0]        dbg_state;

    logic [WR_W-1:0] exp_q[$];
    int total;
    int bad;
    int n_writes;

    program_loader #(
        .DATA_W(DATA_W), .OP_W(OP_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_op(wr_op), .wr_val(wr_val),
        .busy(busy), .load_done(load_done), .load_err(load_err),
        .prog_len(prog_len), .dbg_state(dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'({wr_addr, wr_op, wr_val}), 32'hFFFF_FFFF);
            end else begin
                check("write", 32'({wr_addr, wr_op, wr_val}), 32'(exp_q.pop_front()));
            end
        end
    end

    // Driver tasks (called at #1 after a rising edge)
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom_range(0, 31);
        in_last  = 1'b0;
    endtask

    task automatic send_pair(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] op,
                             input logic [DATA_W-1:0] val, input logic l);
        exp_q.push_back({a, op[OP_W-1:0], val});
        send_word(op, 1'b0);
        send_word(val, l);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("busy_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] op;
        logic [DATA_W-1:0] val;
        int w0;
        total = 0; bad = 0; n_writes = 0;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: reset state, then a two-pair program
        @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(load_done), 0);
        check("rst_err", 32'(load_err), 0);
        check("rst_prog_len", 32'(prog_len), 0);
        check("rst_outs", 32'({wr_addr, wr_op, wr_val}), 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk); #1;
        do_start();
        check("t1_busy_after_start", 32'(busy), 1);
        send_pair(4'd0, 5'h03, 5'h0A, 1'b0);
        send_pair(4'd1, 5'h01, 5'h1F, 1'b1);
        wait_idle();
        check("t1_done", 32'(load_done), 1);
        check("t1_err", 32'(load_err), 0);
        check("t1_len", 32'(prog_len), 2);
        check("t1_q_empty", 32'(exp_q.size()), 0);

        // 2: gap of 4 idle cycles between opcode and operand
        do_start();
        check("t2_done_cleared", 32'(load_done), 0);
        exp_q.push_back({4'd0, 5'h03, 5'h0A});
        send_word(5'h03, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_gap_ready", 32'(in_ready), 1);
            check("t2_gap_wr_en", 32'(wr_en), 0);
        end
        @(posedge clk); #1;
        send_word(5'h0A, 1'b1);
        wait_idle();
        check("t2_done", 32'(load_done), 1);
        check("t2_len", 32'(prog_len), 1);

        // 3: in_last on an opcode word
        w0 = n_writes;
        do_start();
        send_word(5'h02, 1'b1);
        wait_idle();
        check("t3_err", 32'(load_err), 1);
        check("t3_done", 32'(load_done), 0);
        check("t3_len", 32'(prog_len), 0);
        check("t3_no_write", 32'(n_writes - w0), 0);

        // 4a: DEPTH pairs without in_last -> overflow
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            op  = DATA_W'($urandom_range(0, 31));
            val = DATA_W'($urandom_range(0, 31));
            send_pair(ADDR_W'(i), op, val, 1'b0);
        end
        wait_idle();
        check("t4a_err", 32'(load_err), 1);
        check("t4a_done", 32'(load_done), 0);
        check("t4a_len", 32'(prog_len), DEPTH);
        check("t4a_ready", 32'(in_ready), 0);

        // 4b: DEPTH pairs with in_last on the final pair
        do_start();
        check("t4b_err_cleared", 32'(load_err), 0);
        for (int i = 0; i < DEPTH; i++) begin
            op  = DATA_W'($urandom_range(0, 31));
            val = DATA_W'($urandom_range(0, 31));
            send_pair(ADDR_W'(i), op, val, i == DEPTH - 1);
        end
        wait_idle();
        check("t4b_done", 32'(load_done), 1);
        check("t4b_err", 32'(load_err), 0);
        check("t4b_len", 32'(prog_len), DEPTH);

        // 5: start during GET_VAL is ignored; start in DONE restarts at 0
        do_start();
        exp_q.push_back({4'd0, 5'h11, 5'h07});
        send_word(5'h11, 1'b0);
        do_start();
        check("t5_state_get_val", 32'(dbg_state), 32'(GET_VAL));
        check("t5_busy", 32'(busy), 1);
        send_word(5'h07, 1'b0);
        send_pair(4'd1, 5'h12, 5'h08, 1'b1);
        wait_idle();
        check("t5_done", 32'(load_done), 1);
        check("t5_len", 32'(prog_len), 2);
        do_start();
        check("t5_restart_done", 32'(load_done), 0);
        check("t5_restart_len", 32'(prog_len), 0);
        check("t5_restart_busy", 32'(busy), 1);
        send_pair(4'd0, 5'h1C, 5'h15, 1'b1);
        wait_idle();
        check("t5_done2", 32'(load_done), 1);
        check("t5_len2", 32'(prog_len), 1);

        // 6: reset asserted during the WRITE cycle
        do_start();
        send_word(5'h04, 1'b0);
        send_word(5'h09, 1'b0);
        check("t6_in_write", 32'(wr_en), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_wr_en", 32'(wr_en), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_flags", 32'({load_done, load_err, in_ready}), 0);
        check("t6_rst_len", 32'(prog_len), 0);
        check("t6_rst_outs", 32'({wr_addr, wr_op, wr_val}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_state_idle", 32'(dbg_state), 32'(IDLE));
        check("t6_ready", 32'(in_ready), 0);

        repeat (2) @(negedge clk);
        check("final_q_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
